// File: rtl/ide_pkg.sv
// Shared types and constants for the IDE PIO cycle controller.
// Contents: FSM state enum, chip-select decode encodings and helper,
//           IDE_DA / address / counter width constants.
package ide_pkg;

   localparam int unsigned IDE_DA_W  = 3;
   localparam int unsigned IDE_A_W   = 12;
   localparam int unsigned IDE_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_ACK     = 3'd4,
      ST_RECOVER = 3'd5
   } ide_state_t;

   typedef enum logic [1:0] {
      CS_SEL_0    = 2'b00,
      CS_SEL_1    = 2'b01,
      CS_SEL_NONE = 2'b10
   } ide_cs_t;

   // A[13:12]: 00 task file, 01 control block, 1x no drive access
   function automatic ide_cs_t cs_decode(input logic [1:0] a_hi);
      if (a_hi[1])
         return CS_SEL_NONE;
      else if (a_hi[0])
         return CS_SEL_1;
      else
         return CS_SEL_0;
   endfunction

endpackage

// File: rtl/ide_sync2.sv
// Two-flop synchroniser for the asynchronous IORDY input.
// Ports: clk, rst (sync, active high), d (async in), q (synchronised, resets to 1).
module ide_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ide_cycle_ctrl.sv
// ATA PIO register-cycle sequencer for 68040 accesses in the IDE window.
// Produces CS0/CS1, DA[2:0], DIOR/DIOW, data-buffer control, DLATCH and TA/TEA.
// Inputs : CLK40, RESET (sync, active high), IDE_ACCESS, IDE_ENABLE, nTS, nTIP,
//          RnW, A[13:2], IORDY.
// Outputs: nIDE_CS0, nIDE_CS1, IDE_DA, nIDE_DIOR, nIDE_DIOW, IDE_DBUF_OE,
//          IDE_DBUF_DIR, IDE_DLATCH, nIDE_TA, nIDE_TEA.
// Build option: define IDE_IORDY_EN to stretch strobes on IORDY with timeout -> TEA.
module ide_cycle_ctrl
   import ide_pkg::*;
#(
   parameter int unsigned T_SETUP       = 3,
   parameter int unsigned T_STROBE      = 7,
   parameter int unsigned T_RECOVER     = 4,
   parameter int unsigned IORDY_TIMEOUT = 64
) (
   input  logic                CLK40,
   input  logic                RESET,
   input  logic                IDE_ACCESS,
   input  logic                IDE_ENABLE,
   input  logic                nTS,
   input  logic                nTIP,
   input  logic                RnW,
   input  logic [IDE_A_W-1:0]  A,
   input  logic                IORDY,
   output logic                nIDE_CS0,
   output logic                nIDE_CS1,
   output logic [IDE_DA_W-1:0] IDE_DA,
   output logic                nIDE_DIOR,
   output logic                nIDE_DIOW,
   output logic                IDE_DBUF_OE,
   output logic                IDE_DBUF_DIR,
   output logic                IDE_DLATCH,
   output logic                nIDE_TA,
   output logic                nIDE_TEA
);

   localparam logic [IDE_CNT_W-1:0] LD_SETUP   = IDE_CNT_W'(T_SETUP - 1);
   localparam logic [IDE_CNT_W-1:0] LD_STROBE  = IDE_CNT_W'(T_STROBE - 1);
   localparam logic [IDE_CNT_W-1:0] LD_RECOVER = IDE_CNT_W'(T_RECOVER - 1);
   localparam logic [IDE_CNT_W-1:0] LD_TIMEOUT = IDE_CNT_W'(IORDY_TIMEOUT - 1);
   localparam logic [IDE_CNT_W-1:0] CNT_ONE    = IDE_CNT_W'(1);

   ide_state_t           state_q, state_d;
   logic [IDE_CNT_W-1:0] cnt_q, cnt_d;
   logic [IDE_A_W-1:0]   a_q, a_d, launch_a;
   logic                 rnw_q, rnw_d, launch_rnw;
   logic                 ext_q, ext_d;        // strobe is in IORDY extension
   logic                 tmo_q, tmo_d;        // IORDY wait timed out
   logic                 pend_q, pend_d;      // cycle queued during RECOVER
   logic                 tip_lost_q, tip_lost_d;
   logic                 start, launch, cnt_zero, iordy_s, strobe_end_ok, cs_window;
   ide_cs_t              cs_sel;

`ifdef IDE_IORDY_EN
   ide_sync2 u_iordy_sync (
      .clk (CLK40),
      .rst (RESET),
      .d   (IORDY),
      .q   (iordy_s)
   );
`else
   logic unused_iordy;
   assign unused_iordy = IORDY;
   assign iordy_s      = 1'b1;
`endif

   assign start    = ~nTS & IDE_ACCESS & IDE_ENABLE;
   assign cnt_zero = (cnt_q == '0);

   // A new cycle begins from IDLE, or straight out of the last RECOVER cycle
   assign launch     = ((state_q == ST_IDLE) & start) |
                       ((state_q == ST_RECOVER) & cnt_zero & (pend_q | start));
   assign launch_a   = ((state_q == ST_RECOVER) & pend_q) ? a_q   : A;
   assign launch_rnw = ((state_q == ST_RECOVER) & pend_q) ? rnw_q : RnW;

   // State register
   always_ff @(posedge CLK40) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         rnw_q      <= 1'b1;
         ext_q      <= 1'b0;
         tmo_q      <= 1'b0;
         pend_q     <= 1'b0;
         tip_lost_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         rnw_q      <= rnw_d;
         ext_q      <= ext_d;
         tmo_q      <= tmo_d;
         pend_q     <= pend_d;
         tip_lost_q <= tip_lost_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      rnw_d      = rnw_q;
      ext_d      = ext_q;
      tmo_d      = tmo_q;
      pend_d     = pend_q;
      tip_lost_d = tip_lost_q;

      case (state_q)
         ST_IDLE: ;
         ST_SETUP: begin
            if (cnt_zero) begin
               state_d = ST_STROBE;
               cnt_d   = LD_STROBE;
               ext_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_STROBE: begin
            if (!ext_q) begin
               if (!cnt_zero)
                  cnt_d = cnt_q - CNT_ONE;
               else if (iordy_s)
                  state_d = ST_HOLD;
               else begin
                  ext_d = 1'b1;
                  cnt_d = LD_TIMEOUT;
               end
            end else begin
               if (iordy_s)
                  state_d = ST_HOLD;
               else if (cnt_zero) begin
                  state_d = ST_HOLD;
                  tmo_d   = 1'b1;
               end else
                  cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_HOLD:
            state_d = ST_ACK;
         ST_ACK: begin
            state_d = ST_RECOVER;
            cnt_d   = LD_RECOVER;
         end
         ST_RECOVER: begin
            if (start & ~pend_q) begin
               pend_d = 1'b1;
               a_d    = A;
               rnw_d  = RnW;
            end
            if (cnt_zero) begin
               pend_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default:
            state_d = ST_IDLE;
      endcase

      // CPU abandoning the cycle only suppresses the acknowledge
      if (((state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD)) && nTIP)
         tip_lost_d = 1'b1;

      if (launch) begin
         a_d        = launch_a;
         rnw_d      = launch_rnw;
         tip_lost_d = 1'b0;
         tmo_d      = 1'b0;
         ext_d      = 1'b0;
         if (cs_decode(launch_a[IDE_A_W-1 -: 2]) == CS_SEL_NONE)
            state_d = ST_ACK;
         else begin
            state_d = ST_SETUP;
            cnt_d   = LD_SETUP;
         end
      end
   end

   assign cs_sel        = cs_decode(a_q[IDE_A_W-1 -: 2]);
   assign cs_window     = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
   assign strobe_end_ok = iordy_s & (ext_q | cnt_zero);

   // Output decode
   always_comb begin
      nIDE_CS0     = 1'b1;
      nIDE_CS1     = 1'b1;
      IDE_DA       = '0;
      nIDE_DIOR    = 1'b1;
      nIDE_DIOW    = 1'b1;
      IDE_DBUF_OE  = 1'b0;
      IDE_DBUF_DIR = 1'b1;
      IDE_DLATCH   = 1'b0;
      nIDE_TA      = 1'b1;
      nIDE_TEA     = 1'b1;

      if (cs_window) begin
         nIDE_CS0 = (cs_sel != CS_SEL_0);
         nIDE_CS1 = (cs_sel != CS_SEL_1);
         IDE_DA   = a_q[IDE_DA_W-1:0];
      end
      if (state_q == ST_STROBE) begin
         nIDE_DIOR  = ~rnw_q;
         nIDE_DIOW  = rnw_q;
         IDE_DLATCH = rnw_q & strobe_end_ok;
      end
      if (cs_window || (state_q == ST_ACK)) begin
         IDE_DBUF_OE  = 1'b1;
         IDE_DBUF_DIR = rnw_q;
      end
      if ((state_q == ST_ACK) && !tip_lost_q) begin
`ifdef IDE_IORDY_EN
         if (tmo_q)
            nIDE_TEA = 1'b0;
         else
            nIDE_TA = 1'b0;
`else
         nIDE_TA = 1'b0;
`endif
      end
   end

endmodule
